// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, reads instruction + immediate from a
// synchronous ROM, issues them to the multicycle processor and waits for Done.
module fetch_unit #(
  parameter int          DATA_W  = 10,
  parameter int          ADDR_W  = 7,
  parameter logic [3:0]  MVI_OP  = 4'b0001,
  parameter int          TIMEOUT = 7
) (
  input  logic              Clock,
  input  logic              Clear,
  input  logic              Halt,
  output logic [ADDR_W-1:0] Mem_addr,
  input  logic [DATA_W-1:0] Mem_q,
  output logic [DATA_W-1:0] Din,
  output logic              Run,
  input  logic              Done,
  output logic [ADDR_W-1:0] Pc,
  output logic              Fault
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_ADDR,
    S_INSTR,
    S_IMM,
    S_ISSUE,
    S_EXEC
  } state_t;

  state_t             state_reg, state_next;
  logic [ADDR_W-1:0]  pc_reg, pc_next;
  logic [DATA_W-1:0]  instr_reg, instr_next;
  logic [DATA_W-1:0]  imm_reg, imm_next;
  logic [DATA_W-1:0]  din_reg, din_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               fault_reg, fault_next;
  logic [ADDR_W-1:0]  mem_addr_next;

  logic is_mvi;
  logic timeout_hit;

  assign is_mvi      = (instr_reg[DATA_W-1 -: 4] == MVI_OP);
  assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge Clock) begin
    if (Clear) begin
      state_reg <= S_ADDR;
      pc_reg    <= '0;
      instr_reg <= '0;
      imm_reg   <= '0;
      din_reg   <= '0;
      cnt_reg   <= '0;
      fault_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      instr_reg <= instr_next;
      imm_reg   <= imm_next;
      din_reg   <= din_next;
      cnt_reg   <= cnt_next;
      fault_reg <= fault_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    instr_next    = instr_reg;
    imm_next      = imm_reg;
    din_next      = din_reg;
    cnt_next      = cnt_reg;
    fault_next    = fault_reg;
    mem_addr_next = pc_reg;

    case (state_reg)
      S_ADDR: begin
        if (!Halt) begin
          state_next = S_INSTR;
        end
      end
      S_INSTR: begin
        // Address the immediate slot now so it arrives during S_IMM.
        instr_next    = Mem_q;
        mem_addr_next = pc_reg + ADDR_W'(1);
        state_next    = S_IMM;
      end
      S_IMM: begin
        imm_next   = Mem_q;
        din_next   = instr_reg;
        state_next = S_ISSUE;
      end
      S_ISSUE: begin
        // Immediate goes on Din for the whole execute phase (processor step 1 onward).
        cnt_next   = '0;
        din_next   = imm_reg;
        state_next = S_EXEC;
      end
      S_EXEC: begin
        if (Done) begin
          pc_next    = pc_reg + (is_mvi ? ADDR_W'(2) : ADDR_W'(1));
          state_next = S_ADDR;
        end else if (timeout_hit) begin
          fault_next = 1'b1;
          pc_next    = pc_reg + ADDR_W'(1);
          state_next = S_ADDR;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = S_ADDR;
      end
    endcase
  end

  assign Mem_addr = mem_addr_next;
  assign Din      = din_reg;
  assign Run      = (state_reg == S_ISSUE);
  assign Pc       = pc_reg;
  assign Fault    = fault_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle table for the mv/mvi sequence plus directed
// sequences for ALU throughput, PC wrap, Halt, Done timeout and mid-run Clear.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       clear;
  logic       halt;
  logic [6:0] mem_addr;
  logic [9:0] mem_q;
  logic [9:0] din;
  logic       run;
  logic       done;
  logic [6:0] pc;
  logic       fault;

  int errors = 0;
  int checks = 0;

  logic [9:0] rom [128];

  // Processor model: step counter restarted by Run, Done raised at done_at.
  int   step = 0;
  int   done_at = 1;
  logic done_en = 1'b1;
  logic force_en = 1'b0;
  logic force_val = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) mem_q <= rom[mem_addr];

  always @(posedge clk) begin
    if (clear)         step <= 0;
    else if (run)      step <= 1;
    else if (step != 0) step <= step + 1;
  end

  assign done = force_en ? force_val : (done_en && (step == done_at));

  fetch_unit dut (
    .Clock   (clk),
    .Clear   (clear),
    .Halt    (halt),
    .Mem_addr(mem_addr),
    .Mem_q   (mem_q),
    .Din     (din),
    .Run     (run),
    .Done    (done),
    .Pc      (pc),
    .Fault   (fault)
  );

  typedef struct {
    logic       halt;
    logic       done;
    logic       exp_run;
    logic [9:0] exp_din;
    logic [6:0] exp_pc;
    logic       chk_addr;
    logic [6:0] exp_addr;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Counts negedges from the current cycle until Run is seen; -1 if the bound expires.
  task automatic wait_run(input int limit, output int n);
    int  i;
    logic found;
    i = 0;
    found = 1'b0;
    n = -1;
    while (!found && i < limit) begin
      @(negedge clk);
      i++;
      if (run) begin
        found = 1'b1;
        n = i;
      end
    end
  endtask

  task automatic do_reset();
    clear = 1'b1;
    repeat (2) @(posedge clk);
    #1 clear = 1'b0;
  endtask

  task automatic rom_clear();
    for (int a = 0; a < 128; a++) rom[a] = 10'h000;
  endtask

  initial begin
    int n;
    int guard;

    clear = 1'b1;
    halt  = 1'b0;
    rom_clear();

    // mv R1,R2 ; mvi R3,#0x155 -- Done in step 1. Done also pulsed in S_ADDR/S_IMM.
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 10'h000, 7'd0, 1'b1, 7'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 10'h000, 7'd0, 1'b1, 7'd1};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 10'h000, 7'd0, 1'b1, 7'd0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 10'h00A, 7'd0, 1'b0, 7'd0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 10'h058, 7'd0, 1'b0, 7'd0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 10'h058, 7'd1, 1'b1, 7'd1};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 10'h058, 7'd1, 1'b1, 7'd2};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 10'h058, 7'd1, 1'b1, 7'd1};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 10'h058, 7'd1, 1'b0, 7'd0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 10'h155, 7'd1, 1'b0, 7'd0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 10'h155, 7'd3, 1'b1, 7'd3};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 10'h155, 7'd3, 1'b1, 7'd4};

    rom[0] = 10'h00A;
    rom[1] = 10'h058;
    rom[2] = 10'h155;
    force_en  = 1'b1;
    force_val = 1'b0;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      halt      = vecs[i].halt;
      force_val = vecs[i].done;
      @(negedge clk);
      $display("vec %0d: run=%0b din=%03h pc=%0d addr=%0d fault=%0b", i + 1, run, din, pc, mem_addr, fault);
      check("tbl_run",   run,   vecs[i].exp_run);
      check("tbl_din",   din,   vecs[i].exp_din);
      check("tbl_pc",    pc,    vecs[i].exp_pc);
      check("tbl_fault", fault, 1'b0);
      if (vecs[i].chk_addr) check("tbl_addr", mem_addr, vecs[i].exp_addr);
      @(posedge clk);
      #1;
    end
    force_en  = 1'b0;
    force_val = 1'b0;

    // ALU op: Done in EXEC cycle 3 gives 7 cycles per instruction.
    rom_clear();
    rom[0] = 10'h081;
    rom[1] = 10'h2AA;
    done_en = 1'b1;
    done_at = 3;
    do_reset();
    wait_run(20, n);
    $display("alu: first run after %0d cycles", n);
    check("alu_first_run", n, 4);
    check("alu_first_din", din, 10'h081);
    wait_run(20, n);
    $display("alu: next run after %0d cycles pc=%0d", n, pc);
    check("alu_period", n, 7);
    check("alu_pc", pc, 7'd1);
    check("alu_next_din", din, 10'h2AA);

    // Wrap: mvi at 127 takes its immediate from address 0 and continues at 1.
    rom_clear();
    rom[0]   = 10'h3FF;
    rom[127] = 10'h058;
    done_at  = 1;
    do_reset();
    guard = 0;
    @(negedge clk);
    while (pc != 7'd127 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check("wrap_reach_127", pc, 7'd127);
    @(negedge clk);
    check("wrap_instr_addr", mem_addr, 7'd0);
    @(negedge clk);
    @(negedge clk);
    check("wrap_run", run, 1'b1);
    check("wrap_instr_din", din, 10'h058);
    @(negedge clk);
    check("wrap_imm_din", din, 10'h3FF);
    @(negedge clk);
    $display("wrap: pc after mvi at 127 = %0d", pc);
    check("wrap_next_pc", pc, 7'd1);

    // Halt raised in EXEC: instruction completes, unit parks at Pc=1.
    rom_clear();
    rom[0] = 10'h00A;
    rom[1] = 10'h00B;
    do_reset();
    wait_run(20, n);
    check("halt_first_run", n, 4);
    @(posedge clk);
    #1 halt = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("halt_run_low", run, 1'b0);
    end
    $display("halt: parked pc=%0d din=%03h", pc, din);
    check("halt_pc", pc, 7'd1);
    check("halt_din_hold", din, 10'h00B);
    check("halt_addr", mem_addr, 7'd1);
    @(posedge clk);
    #1 halt = 1'b0;
    wait_run(20, n);
    $display("halt: resume run after %0d cycles", n);
    check("halt_resume", n, 4);

    // Timeout: no Done at all.
    rom_clear();
    rom[0] = 10'h081;
    rom[1] = 10'h2AA;
    done_en = 1'b0;
    do_reset();
    wait_run(20, n);
    check("to_first_run", n, 4);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("to_fault_low", fault, 1'b0);
    end
    @(negedge clk);
    $display("timeout: fault=%0b pc=%0d", fault, pc);
    check("to_fault_set", fault, 1'b1);
    check("to_pc", pc, 7'd1);
    // Counted from the cycle after the S_ADDR check, so cycle 4 of the refetch is 3.
    wait_run(20, n);
    check("to_refetch", n, 3);
    check("to_din", din, 10'h2AA);
    check("to_fault_sticky", fault, 1'b1);

    // Clear for one cycle in EXEC cycle 2, with a stale Done the cycle after.
    done_en = 1'b1;
    done_at = 3;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    force_en  = 1'b1;
    force_val = 1'b1;
    @(negedge clk);
    $display("clear: pc=%0d run=%0b din=%03h fault=%0b", pc, run, din, fault);
    check("clr_pc", pc, 7'd0);
    check("clr_run", run, 1'b0);
    check("clr_din", din, 10'h000);
    check("clr_fault", fault, 1'b0);
    check("clr_addr", mem_addr, 7'd0);
    @(posedge clk);
    #1 force_en = 1'b0;
    force_val = 1'b0;
    wait_run(20, n);
    check("clr_reissue", n, 3);
    check("clr_reissue_pc", pc, 7'd0);
    check("clr_reissue_din", din, 10'h081);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
